lc3_regfile: RTL
================

// Module: lc3_regfile
// PURPOSE
//  LC-3 general-purpose register file (R0-R7) plus NZP condition-code register.
//  Supplies both ALU operands (sel 00 NOT, 01 AND, 10 ADD) and accepts the
//  write-back result, i.e. the producer/consumer end of the ALU datapath.
//  Two asynchronous read ports, one synchronous write port, CC derived from
//  written data. Sits between the decode/control FSM and the ALU.
// PARAMETERS
//  WIDTH      16   data width of each register and of wr_data
//  NREGS       8   number of registers; address width = $clog2(NREGS) = 3
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  rd_a_addr  in   3      read port A address (ALU operand a, SR1)
//  rd_a_data  out  16     read port A data
//  rd_b_addr  in   3      read port B address (ALU operand b, SR2)
//  rd_b_data  out  16     read port B data
//  we         in   1      register write enable
//  wr_addr    in   3      write address (DR)
//  wr_data    in   16     write data (ALU o, or memory data for LD*)
//  cc_we      in   1      condition-code update enable
//  nzp        out  3      {N,Z,P} condition code, exactly one bit set
// BEHAVIOUR
//  - Reset (rst=1 at posedge): R0..R7 <= 16'h0000, nzp <= 3'b010; rst
//    overrides we and cc_we in the same cycle. Read ports show reset values
//    from the cycle after the reset edge.
//  - Reads: combinational, zero latency; rd_x_data = R[rd_x_addr]. Both ports
//    may address the same register; both return the same value.
//  - Write: at posedge with we=1 and rst=0, R[wr_addr] <= wr_data. Visible on
//    read ports the cycle after the edge (one-cycle write latency).
//  - CC: at posedge with cc_we=1 and rst=0, nzp <= 3'b100 if wr_data[15]=1;
//    3'b010 if wr_data==0; 3'b001 otherwise. cc_we is independent of we
//    (CC may update with no register write); computed from wr_data only.
//  - cc_we=0: nzp holds. we=0: all registers hold.
//  - No R0 special case: R0 is a normal writable register.
//  - Out-of-range addresses impossible (3-bit, NREGS=8); for NREGS<8 writes
//    to unimplemented addresses are dropped, reads return 0.
//  - nzp is never 000 or multi-hot after the first reset.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: write-through bypass. If we=1 and
//    rd_x_addr==wr_addr in the same cycle, rd_x_data = wr_data (combinational)
//    instead of the stored value; applies independently to ports A and B.
//    nzp is never bypassed.
//  REGFILE_BYPASS_EN undefined: reads always return stored contents; a
//    same-cycle read of the register being written returns the old value.
// TESTING
//  1 Reset: rst=1 one edge -> all 8 regs read 0x0000 on both ports, nzp=010.
//  2 Write/read: we=1 R3<=0x1234, then R5<=0xFFFF -> A@3=0x1234, B@5=0xFFFF,
//    A@5=B@5=0xFFFF; other regs still 0x0000.
//  3 CC: cc_we=1, wr_data=0x0000 -> nzp=010; 0x8000 -> 100; 0x0064 -> 001;
//    cc_we=0, wr_data=0x8000 -> nzp stays 001.
//  4 ALU loop: R1=3, R2=2; A@1,B@2 into ALU ADD, we=1 wr_addr=4 cc_we=1 ->
//    next cycle R4=0x0005, nzp=001; repeat with R2=0xFFFF -> R4=0x0002.
//  5 Same-cycle read/write: R6=0x00AA, then we=1 wr_addr=6 wr_data=0x0055,
//    A@6 during that cycle -> 0x0055 with REGFILE_BYPASS_EN, 0x00AA without;
//    0x0055 on both builds next cycle.
//  6 Reset priority: R7=0x7777, nzp=001; rst=1 with we=1 wr_addr=7
//    wr_data=0x1111 cc_we=1 -> R7=0x0000, nzp=010.

Source files
------------

// File: rtl/lc3_regfile.sv
// LC-3 register file R0..R(NREGS-1) with two async read ports, one sync write port and NZP flags.
// Optional write-through bypass on the read ports is enabled by defining REGFILE_BYPASS_EN.
module lc3_regfile #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREGS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       rd_a_addr,
    output logic [WIDTH-1:0] rd_a_data,
    input  logic [2:0]       rd_b_addr,
    output logic [WIDTH-1:0] rd_b_data,
    input  logic             we,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             cc_we,
    output logic [2:0]       nzp
);

    localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [2:0]       nzp_q;
    logic [2:0]       nzp_d;

    logic             wr_ok;
    logic             rd_a_ok;
    logic             rd_b_ok;
    logic [WIDTH-1:0] rd_a_stored;
    logic [WIDTH-1:0] rd_b_stored;

    // Addresses beyond NREGS only exist when the file is built smaller than 8 entries.
    assign wr_ok   = 32'(wr_addr) < NREGS;
    assign rd_a_ok = 32'(rd_a_addr) < NREGS;
    assign rd_b_ok = 32'(rd_b_addr) < NREGS;

    always_comb begin
        if (wr_data[WIDTH-1]) begin
            nzp_d = 3'b100;
        end else if (wr_data == '0) begin
            nzp_d = 3'b010;
        end else begin
            nzp_d = 3'b001;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
            nzp_q <= 3'b010;
        end else begin
            if (we && wr_ok) begin
                regs_q[wr_addr[AW-1:0]] <= wr_data;
            end
            if (cc_we) begin
                nzp_q <= nzp_d;
            end
        end
    end

    always_comb begin
        rd_a_stored = '0;
        rd_b_stored = '0;
        if (rd_a_ok) begin
            rd_a_stored = regs_q[rd_a_addr[AW-1:0]];
        end
        if (rd_b_ok) begin
            rd_b_stored = regs_q[rd_b_addr[AW-1:0]];
        end
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        rd_a_data = rd_a_stored;
        rd_b_data = rd_b_stored;
        if (we && wr_ok && (rd_a_addr == wr_addr)) begin
            rd_a_data = wr_data;
        end
        if (we && wr_ok && (rd_b_addr == wr_addr)) begin
            rd_b_data = wr_data;
        end
    end
`else
    always_comb begin
        rd_a_data = rd_a_stored;
        rd_b_data = rd_b_stored;
    end
`endif

    assign nzp = nzp_q;

endmodule
